// File: rtl/station_cmd_ctrl.sv
// Station command controller: takes go/stop commands and barcode station IDs,
// enables motion while in transit, and drives the piezo when the path is blocked.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no destination active, motion disabled
// TRANSIT | heading to dest_id, motion enabled when path clear
module station_cmd_ctrl #(
    parameter int unsigned BUZZ_HALF = 12500,
    parameter logic [1:0]  CMD_GO    = 2'b01,
    parameter logic [1:0]  CMD_STOP  = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd,
    input  logic       cmd_rdy,
    output logic       clr_cmd_rdy,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_ID_vld,
    input  logic       OK2Move,
    output logic       go,
    output logic       in_transit,
    output logic       buzz,
    output logic       buzz_n
);

    localparam int unsigned CW = $clog2(BUZZ_HALF);
    localparam logic [CW-1:0] CNT_MAX = CW'(BUZZ_HALF - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        TRANSIT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [5:0]    dest_id, dest_id_nxt;
    logic [CW-1:0] buzz_cnt;
    logic          buzz_en;
    logic [1:0]    opcode;
    logic          unused_id_hi;

    // Decoder guarantees the top two ID bits are zero.
    assign unused_id_hi = ^ID[7:6];
    assign opcode       = cmd[7:6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dest_id <= 6'd0;
        end else begin
            state   <= state_nxt;
            dest_id <= dest_id_nxt;
        end
    end

    // Commands take priority; a simultaneous ID stays pending for the next cycle.
    always_comb begin
        state_nxt   = state;
        dest_id_nxt = dest_id;
        clr_cmd_rdy = 1'b0;
        clr_ID_vld  = 1'b0;
        if (cmd_rdy) begin
            clr_cmd_rdy = 1'b1;
            case (state)
                IDLE: begin
                    if (opcode == CMD_GO) begin
                        dest_id_nxt = cmd[5:0];
                        state_nxt   = TRANSIT;
                    end
                end
                TRANSIT: begin
                    if (opcode == CMD_GO) begin
                        dest_id_nxt = cmd[5:0];
                    end else if (opcode == CMD_STOP) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (ID_vld) begin
            clr_ID_vld = 1'b1;
            if ((state == TRANSIT) && (ID[5:0] == dest_id)) begin
                state_nxt = IDLE;
            end
        end
    end

    assign in_transit = (state == TRANSIT);
    assign go         = in_transit & OK2Move;
    assign buzz_en    = in_transit & ~OK2Move;

    // Leaving the blocked condition returns the piezo to a defined rest state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buzz_cnt <= '0;
            buzz     <= 1'b0;
            buzz_n   <= 1'b1;
        end else if (buzz_en) begin
            if (buzz_cnt == CNT_MAX) begin
                buzz_cnt <= '0;
                buzz     <= ~buzz;
                buzz_n   <= buzz;
            end else begin
                buzz_cnt <= buzz_cnt + CW'(1);
            end
        end else begin
            buzz_cnt <= '0;
            buzz     <= 1'b0;
            buzz_n   <= 1'b1;
        end
    end

endmodule
